custom_insn_ctrl: RTL and testbench

Sequencer for the core's custom-opcode instructions (opcode 1101011). It sits beside the execute stage and accepts a decoded custom instruction plus its operand values, and validates funct7/funct3. It runs the multi-cycle CRC6 datapath for funct3 000, and signals illegal for the unused slots 001/010 and every other encoding. It holds the core stalled while busy and returns a register-file write through a done/ack handshake.

---
 rtl/custom_insn_ctrl.sv | 161 ++++++++++++++++
 tb/tb_custom_insn_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/custom_insn_ctrl.sv
// custom_insn_ctrl
// Sequencer for custom-opcode (1101011) instructions. It accepts a decoded
// instruction with its operands and checks the encoding. Legal CRC6 ops
// (funct7=0, funct3=000) run a multi-cycle CRC over rs1, seeded from
// rs2[5:0]. Everything else finishes at once with the illegal flag set.
//
// Handshakes:
//   accept : i_valid is sampled only while o_ready=1 (IDLE). The instruction
//            is taken on the rising edge where i_valid=1 and i_flush=0.
//   result : o_done is held with stable rd/illegal/data until an edge with
//            i_ack=1. i_ack is ignored unless o_done=1.
//   flush  : i_flush forces IDLE on the next edge. It has priority over
//            i_valid and i_ack and produces no result.
//
// Ports:
//   i_clk, i_rst_n         clock, async active-low reset
//   i_valid / o_ready      instruction accept handshake
//   i_instr, i_rs1, i_rs2  instruction word, CRC data word, CRC seed
//   i_flush                abort any in-flight operation
//   o_busy                 stall request (BUSY or DONE)
//   o_done / i_ack         result handshake
//   o_rd_we, o_rd_addr,
//   o_rd_data, o_illegal   register-file write and illegal flag
//   o_dbg_state            current FSM state, for observation only
module custom_insn_ctrl #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  input  logic        i_flush,
  output logic        o_busy,
  output logic        o_done,
  input  logic        i_ack,
  output logic        o_rd_we,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd_data,
  output logic        o_illegal,
  output logic [1:0]  o_dbg_state
);

  localparam int N  = 32 / BITS_PER_CYCLE;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [5:0]      crc_q, crc_d;
  logic [31:0]     sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4:0]      rd_q, rd_d;
  logic            illegal_q, illegal_d;

  logic [5:0]      crc_nx;
  logic            fb;
  logic            legal;

  // Encoding bits that play no part in this block.
  logic            unused_bits;
  assign unused_bits = ^{i_instr[24:15], i_rs2[31:6]};

  assign legal = (i_instr[6:0] == 7'b1101011) &&
                 (i_instr[31:25] == 7'd0) &&
                 (i_instr[14:12] == 3'b000);

  // One beat of the CRC: BITS_PER_CYCLE data bits, MSB-first from the top
  // of the shift register.
  always_comb begin
    crc_nx = crc_q;
    fb     = 1'b0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      fb     = crc_nx[5] ^ sr_q[31-i];
      crc_nx = {crc_nx[4:0], 1'b0} ^ (fb ? 6'h03 : 6'h00);
    end
  end

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    illegal_d = illegal_q;

    if (i_flush) begin
      state_d   = ST_IDLE;
      illegal_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid) begin
            rd_d = i_instr[11:7];
            if (legal) begin
              crc_d     = i_rs2[5:0];
              sr_d      = i_rs1;
              cnt_d     = CW'(N);
              illegal_d = 1'b0;
              state_d   = ST_BUSY;
            end else begin
              crc_d     = 6'd0;
              sr_d      = 32'd0;
              illegal_d = 1'b1;
              state_d   = ST_DONE;
            end
          end
        end
        ST_BUSY: begin
          crc_d = crc_nx;
          sr_d  = sr_q << BITS_PER_CYCLE;
          cnt_d = cnt_q - CW'(1);
          // The edge that consumes the last beat also enters DONE.
          if (cnt_q == CW'(1)) state_d = ST_DONE;
        end
        ST_DONE: begin
          if (i_ack) begin
            state_d   = ST_IDLE;
            illegal_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      crc_q     <= 6'd0;
      sr_q      <= 32'd0;
      cnt_q     <= '0;
      rd_q      <= 5'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      illegal_q <= illegal_d;
    end
  end

  assign o_ready     = (state_q == ST_IDLE);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = (state_q == ST_DONE);
  // Writes to x0 are dropped but the result is still handed back.
  assign o_rd_we     = o_done & ~illegal_q & (rd_q != 5'd0);
  assign o_rd_addr   = rd_q;
  assign o_rd_data   = {26'd0, crc_q};
  assign o_illegal   = illegal_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_custom_insn_ctrl.sv
module tb_custom_insn_ctrl;

  localparam int NI = 6;  // one DUT per BITS_PER_CYCLE in {1,2,4,8,16,32}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        valid, flush, ack;
  logic [31:0] instr, rs1, rs2;

  logic        rdy_o  [NI];
  logic        busy_o [NI];
  logic        done_o [NI];
  logic        we_o   [NI];
  logic        ill_o  [NI];
  logic [4:0]  addr_o [NI];
  logic [31:0] data_o [NI];
  logic [1:0]  dbg_o  [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    custom_insn_ctrl #(.BITS_PER_CYCLE(1 << g)) u_dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_valid     (valid),
      .o_ready     (rdy_o[g]),
      .i_instr     (instr),
      .i_rs1       (rs1),
      .i_rs2       (rs2),
      .i_flush     (flush),
      .o_busy      (busy_o[g]),
      .o_done      (done_o[g]),
      .i_ack       (ack),
      .o_rd_we     (we_o[g]),
      .o_rd_addr   (addr_o[g]),
      .o_rd_data   (data_o[g]),
      .o_illegal   (ill_o[g]),
      .o_dbg_state (dbg_o[g])
    );
  end

  // ---------------- counters / check helper ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h (t=%0t)", nm, k, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [5:0] crc6(input logic [31:0] d, input logic [5:0] seed);
    logic [5:0] c;
    logic       f;
    c = seed;
    for (int i = 31; i >= 0; i--) begin
      f = c[5] ^ d[i];
      c = {c[4:0], 1'b0} ^ (f ? 6'h03 : 6'h00);
    end
    return c;
  endfunction

  function automatic bit is_legal(input logic [31:0] ins);
    return (ins[6:0] == 7'b1101011) && (ins[31:25] == 7'd0) && (ins[14:12] == 3'd0);
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, 7'b1101011};
  endfunction

  // Scoreboard: one entry per accepted op, {illegal, rd, data}.
  logic [37:0] exp_q[$];
  logic [37:0] e;

  int  cyc = 0;
  int  n_deliv = 0;
  bit  pend [NI];
  int  due  [NI];
  bit  dn_now [NI];
  int  lat  [NI];
  bit  lg;

  initial for (int k = 0; k < NI; k++) lat[k] = 32 / (1 << k);

  // Result of an op is due "latency" edges after its accept edge; pending
  // means accepted and not yet acked or flushed.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NI; k++) pend[k] = 1'b0;
      exp_q.delete();
    end else begin
      lg = is_legal(instr);
      for (int k = 0; k < NI; k++) dn_now[k] = pend[k] && (cyc >= due[k]);
      if (dn_now[0] && ack && !flush) n_deliv++;
      if (pend[0] && (flush || (dn_now[0] && ack))) void'(exp_q.pop_front());
      if (!pend[0] && valid && !flush)
        exp_q.push_back({!lg, instr[11:7], lg ? {26'd0, crc6(rs1, rs2[5:0])} : 32'd0});
      cyc++;
      for (int k = 0; k < NI; k++) begin
        if (flush) pend[k] = 1'b0;
        else if (!pend[k] && valid) begin
          pend[k] = 1'b1;
          due[k]  = lg ? cyc + lat[k] : cyc;
        end else if (dn_now[k] && ack) pend[k] = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit exp_done;
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < NI; k++) begin
        exp_done = pend[k] && (cyc >= due[k]);
        chk("ready", k, rdy_o[k], !pend[k]);
        chk("busy",  k, busy_o[k], pend[k]);
        chk("done",  k, done_o[k], exp_done);
        if (exp_done && exp_q.size() > 0) begin
          e = exp_q[0];
          chk("illegal", k, ill_o[k], e[37]);
          chk("rd_addr", k, addr_o[k], e[36:32]);
          chk("rd_data", k, data_o[k], e[31:0]);
          chk("rd_we",   k, we_o[k], !e[37] && (e[36:32] != 5'd0));
        end else begin
          chk("rd_we_idle", k, we_o[k], 1'b0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic bit all_idle();
    for (int k = 0; k < NI; k++) if (pend[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle();
    int t = 0;
    while (!all_idle() && t < 200) begin @(negedge clk); t++; end
    chk("idle_wait", 0, t < 200, 1'b1);
  endtask

  // Presents one instruction; returns at the negedge right after accept.
  task automatic send(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
    wait_idle();
    @(negedge clk);
    valid = 1'b1; instr = ins; rs1 = r1; rs2 = r2;
    @(negedge clk);
    valid = 1'b0;
    rs1 = $urandom; rs2 = $urandom;  // operands must already be latched
  endtask

  task automatic give_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic run_op(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2, input int dly);
    send(ins, r1, r2);
    repeat (32 + dly) @(negedge clk);
    give_ack();
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int k = 0; k < NI; k++) begin
      chk({tag, "_ready"}, k, rdy_o[k], 1'b1);
      chk({tag, "_busy"},  k, busy_o[k], 1'b0);
      chk({tag, "_done"},  k, done_o[k], 1'b0);
      chk({tag, "_we"},    k, we_o[k], 1'b0);
      chk({tag, "_addr"},  k, addr_o[k], 5'd0);
      chk({tag, "_data"},  k, data_o[k], 32'd0);
      chk({tag, "_ill"},   k, ill_o[k], 1'b0);
    end
  endtask

  // ---------------- stimulus ----------------
  int first_done [NI];
  int d0;
  logic [6:0] f7;
  logic [2:0] f3;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; valid = 1'b0; flush = 1'b0; ack = 1'b0;
    instr = '0; rs1 = '0; rs2 = '0;
    #12;
    chk_reset_vals("rst");
    @(negedge clk); #2 rst_n = 1'b1;

    // Literal pins of the model's CRC rule.
    chk("model_v1", 0, crc6(32'h1, 6'h0), 6'h03);
    chk("model_v2", 0, crc6(32'h0, 6'h0), 6'h00);
    chk("model_v3", 0, crc6(32'h8000_0000, 6'h20), 6'h00);

    // Vector 1 with measured latency and literal result.
    wait_idle();
    @(negedge clk);
    valid = 1'b1; instr = mk(7'd0, 3'd0, 5'd5); rs1 = 32'h1; rs2 = 32'h0;
    for (int k = 0; k < NI; k++) first_done[k] = -1;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      valid = 1'b0;
      for (int k = 0; k < NI; k++) if (done_o[k] && first_done[k] < 0) first_done[k] = t;
    end
    for (int k = 0; k < NI; k++) begin
      chk("v1_latency", k, first_done[k] - 1, 32 / (1 << k));
      chk("v1_data", k, data_o[k], 32'h3);
      chk("v1_addr", k, addr_o[k], 5'd5);
      chk("v1_we",   k, we_o[k], 1'b1);
    end
    give_ack();

    run_op(mk(7'd0, 3'd0, 5'd7), 32'h0, 32'h0, 0);
    run_op(mk(7'd0, 3'd0, 5'd9), 32'h8000_0000, 32'h20, 1);

    // Illegal encodings.
    run_op(mk(7'd0, 3'b001, 5'd3), 32'h1234_5678, 32'h3f, 0);
    run_op(mk(7'd0, 3'b010, 5'd4), 32'hdead_beef, 32'h11, 0);
    run_op(mk(7'd1, 3'b000, 5'd6), 32'hcafe_f00d, 32'h05, 0);

    // rd = x0: done but no write.
    run_op(mk(7'd0, 3'd0, 5'd0), 32'ha5a5_5a5a, 32'h2a, 0);

    // Ack held off 5 cycles; exactly one result delivered.
    d0 = n_deliv;
    run_op(mk(7'd0, 3'd0, 5'd12), 32'h0f0f_1234, 32'h15, 5);
    @(negedge clk);
    chk("one_result", 0, n_deliv - d0, 1);

    // Flush on BUSY cycle 3: no result.
    d0 = n_deliv;
    send(mk(7'd0, 3'd0, 5'd13), 32'h7777_0001, 32'h01);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (40) @(negedge clk);
    chk("flush_no_result", 0, n_deliv - d0, 0);

    // Flush together with valid in IDLE: not accepted.
    wait_idle();
    @(negedge clk);
    valid = 1'b1; flush = 1'b1; instr = mk(7'd0, 3'd0, 5'd14); rs1 = 32'h1;
    @(negedge clk);
    valid = 1'b0; flush = 1'b0;
    for (int k = 0; k < NI; k++) chk("flush_idle_ready", k, rdy_o[k], 1'b1);

    // Reset mid-BUSY: outputs drop at once, no result ever follows.
    d0 = n_deliv;
    send(mk(7'd0, 3'd0, 5'd15), 32'h1357_9bdf, 32'h33);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("rst_no_result", 0, n_deliv - d0, 0);

    // Random ops, mostly legal.
    for (int n = 0; n < 1000; n++) begin
      f7 = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
      f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      run_op(mk(f7, f3, 5'($urandom_range(0, 31))), $urandom, $urandom, $urandom_range(0, 2));
    end

    wait_idle();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
